// File: rtl/count_snapshot_fifo.sv
// Snapshot FIFO for a free-running counter: each capture stores the counter value
// together with a tag that records whether the counter wrapped since the previous capture.
module count_snapshot_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int LVLW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             capture,
  input  logic             clr_ovf,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH:0]   rd_data,
  output logic [LVLW-1:0]  level,
  output logic             full,
  output logic             overflow
);

  localparam int PTRW = $clog2(DEPTH);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0]  level_q, level_d;
  logic [WIDTH-1:0] prev_cnt_q;
  logic             wrap_pend_q, wrap_pend_d;
  logic             overflow_q, overflow_d;

  logic wrap_now;
  logic read_fire;
  logic wr_accept;
  logic wr_drop;

  assign full     = (level_q == LVLW'(DEPTH));
  assign rd_valid = (level_q != '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  // Storage is not reset, so the head entry is masked until something has been written.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wrap_now    = (cnt_in < prev_cnt_q);
    read_fire   = rd_valid & rd_ready;
    wr_accept   = capture & (~full | read_fire);
    wr_drop     = capture & full & ~read_fire;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wrap_pend_d = wrap_pend_q;
    overflow_d  = overflow_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (read_fire) rd_ptr_d = rd_ptr_q + PTRW'(1);

    unique case ({wr_accept, read_fire})
      2'b10:   level_d = level_q + LVLW'(1);
      2'b01:   level_d = level_q - LVLW'(1);
      default: level_d = level_q;
    endcase

    // A wrap seen on the accepting edge is already in that entry's tag; otherwise
    // an accepted capture consumes the pending wrap.
    if (wr_accept) begin
      if (!wrap_now) wrap_pend_d = 1'b0;
    end else if (wrap_now) begin
      wrap_pend_d = 1'b1;
    end

    if (wr_drop)      overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      prev_cnt_q  <= '0;
      wrap_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      prev_cnt_q  <= cnt_in;
      wrap_pend_q <= wrap_pend_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; the level counter alone decides which
  // entries are meaningful, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= {wrap_pend_q | wrap_now, cnt_in};
  end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo: a vector table of per-edge stimulus and
// post-edge expectations, plus hand-written reset sequences.
module tb_count_snapshot_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LVLW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] cnt_in;
  logic             capture;
  logic             clr_ovf;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH:0]   rd_data;
  logic [LVLW-1:0]  level;
  logic             full;
  logic             overflow;

  count_snapshot_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVLW(LVLW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_in   (cnt_in),
    .capture  (capture),
    .clr_ovf  (clr_ovf),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             cap;
    logic             clr;
    logic             rdy;
    logic             valid;
    logic [WIDTH:0]   data;
    logic [LVLW-1:0]  lvl;
    logic             full;
    logic             ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic [WIDTH-1:0] cnt, input logic cap, clr, rdy,
                              input logic valid, input logic [WIDTH:0] data,
                              input logic [LVLW-1:0] lvl, input logic fl, ovf);
    vec_t v;
    v.cnt = cnt; v.cap = cap; v.clr = clr; v.rdy = rdy;
    v.valid = valid; v.data = data; v.lvl = lvl; v.full = fl; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(v.valid));
    check({tag, ".rd_data"},  32'(rd_data),  32'(v.data));
    check({tag, ".level"},    32'(level),    32'(v.lvl));
    check({tag, ".full"},     32'(full),     32'(v.full));
    check({tag, ".overflow"}, 32'(overflow), 32'(v.ovf));
  endtask

  task automatic apply(input vec_t v);
    cnt_in   = v.cnt;
    capture  = v.cap;
    clr_ovf  = v.clr;
    rd_ready = v.rdy;
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    apply(v);
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    //            cnt  cap clr rdy  val data   lvl  full ovf
    // in-order capture then drain
    vecs.push_back(mk(4'd3,  1, 0, 0,  1, 5'h03, 3'd1, 0, 0));
    vecs.push_back(mk(4'd4,  1, 0, 0,  1, 5'h03, 3'd2, 0, 0));
    vecs.push_back(mk(4'd5,  1, 0, 0,  1, 5'h03, 3'd3, 0, 0));
    vecs.push_back(mk(4'd5,  0, 0, 1,  1, 5'h04, 3'd2, 0, 0));
    vecs.push_back(mk(4'd5,  0, 0, 1,  1, 5'h05, 3'd1, 0, 0));
    vecs.push_back(mk(4'd5,  0, 0, 1,  0, 5'h00, 3'd0, 0, 0));
    vecs.push_back(mk(4'd5,  0, 0, 1,  0, 5'h00, 3'd0, 0, 0));
    // wrap between captures: 13,14(cap),15,0,1(cap)
    vecs.push_back(mk(4'd13, 0, 0, 0,  0, 5'h00, 3'd0, 0, 0));
    vecs.push_back(mk(4'd14, 1, 0, 0,  1, 5'h0E, 3'd1, 0, 0));
    vecs.push_back(mk(4'd15, 0, 0, 0,  1, 5'h0E, 3'd1, 0, 0));
    vecs.push_back(mk(4'd0,  0, 0, 0,  1, 5'h0E, 3'd1, 0, 0));
    vecs.push_back(mk(4'd1,  1, 0, 0,  1, 5'h0E, 3'd2, 0, 0));
    vecs.push_back(mk(4'd1,  0, 0, 1,  1, 5'h11, 3'd1, 0, 0));
    vecs.push_back(mk(4'd1,  0, 0, 1,  0, 5'h00, 3'd0, 0, 0));
    // wrap on the capture edge itself, then no wrap
    vecs.push_back(mk(4'd15, 0, 0, 0,  0, 5'h00, 3'd0, 0, 0));
    vecs.push_back(mk(4'd0,  1, 0, 0,  1, 5'h10, 3'd1, 0, 0));
    vecs.push_back(mk(4'd1,  0, 0, 0,  1, 5'h10, 3'd1, 0, 0));
    vecs.push_back(mk(4'd2,  1, 0, 0,  1, 5'h10, 3'd2, 0, 0));
    vecs.push_back(mk(4'd2,  0, 0, 1,  1, 5'h02, 3'd1, 0, 0));
    vecs.push_back(mk(4'd2,  0, 0, 1,  0, 5'h00, 3'd0, 0, 0));
    // write+read while empty: write only
    vecs.push_back(mk(4'd6,  1, 0, 1,  1, 5'h06, 3'd1, 0, 0));
    // fill, drop, then simultaneous write+read while full
    vecs.push_back(mk(4'd7,  1, 0, 0,  1, 5'h06, 3'd2, 0, 0));
    vecs.push_back(mk(4'd8,  1, 0, 0,  1, 5'h06, 3'd3, 0, 0));
    vecs.push_back(mk(4'd8,  1, 0, 0,  1, 5'h06, 3'd4, 1, 0));
    vecs.push_back(mk(4'd9,  1, 0, 0,  1, 5'h06, 3'd4, 1, 1));
    vecs.push_back(mk(4'd7,  0, 0, 0,  1, 5'h06, 3'd4, 1, 1));
    vecs.push_back(mk(4'd7,  1, 0, 1,  1, 5'h07, 3'd4, 1, 1));
    // drop and clear on the same edge: set wins; then clear alone
    vecs.push_back(mk(4'd7,  1, 1, 0,  1, 5'h07, 3'd4, 1, 1));
    vecs.push_back(mk(4'd7,  0, 1, 0,  1, 5'h07, 3'd4, 1, 0));
    // drain across the pointer wrap; the 7 (tagged) comes out last
    vecs.push_back(mk(4'd7,  0, 0, 1,  1, 5'h08, 3'd3, 0, 0));
    vecs.push_back(mk(4'd7,  0, 0, 1,  1, 5'h08, 3'd2, 0, 0));
    vecs.push_back(mk(4'd7,  0, 0, 1,  1, 5'h17, 3'd1, 0, 0));
    vecs.push_back(mk(4'd7,  0, 0, 1,  0, 5'h00, 3'd0, 0, 0));

    reset = 1'b0;
    apply(mk(4'd0, 0, 0, 0, 0, 5'h00, 3'd0, 0, 0));
    #12;
    check_outs("por", mk(4'd0, 0, 0, 0, 0, 5'h00, 3'd0, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

    // Build up 3 entries with overflow set, then reset between clock edges.
    step("m0", mk(4'd3,  1, 0, 0, 1, 5'h13, 3'd1, 0, 0));
    step("m1", mk(4'd4,  1, 0, 0, 1, 5'h13, 3'd2, 0, 0));
    step("m2", mk(4'd5,  1, 0, 0, 1, 5'h13, 3'd3, 0, 0));
    step("m3", mk(4'd12, 1, 0, 0, 1, 5'h13, 3'd4, 1, 0));
    step("m4", mk(4'd12, 1, 0, 0, 1, 5'h13, 3'd4, 1, 1));
    step("m5", mk(4'd12, 0, 0, 1, 1, 5'h04, 3'd3, 0, 1));
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", mk(4'd0, 0, 0, 0, 0, 5'h00, 3'd0, 0, 0));
    apply(mk(4'd12, 0, 0, 0, 0, 5'h00, 3'd0, 0, 0));
    @(posedge clk);
    #1;
    check_outs("rst_held", mk(4'd0, 0, 0, 0, 0, 5'h00, 3'd0, 0, 0));

    // First edge after release: prev_cnt restarts at 0, so 1 carries no wrap tag.
    @(negedge clk);
    reset = 1'b1;
    apply(mk(4'd1, 1, 0, 0, 0, 5'h00, 3'd0, 0, 0));
    @(posedge clk);
    #1;
    check_outs("post_rst", mk(4'd1, 1, 0, 0, 1, 5'h01, 3'd1, 0, 0));
    step("post_drain", mk(4'd1, 0, 0, 1, 0, 5'h00, 3'd0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream consumer of the 4-bit free-running counter register output.
- On each `capture` strobe, stores a snapshot of the counter value into a small FIFO. Each snapshot is tagged with a flag that says whether the counter wrapped since the previous capture.
- Snapshots are drained by a valid/ready read port.
- Reports fill level and a sticky overflow flag for dropped captures.

Parameters:
- WIDTH, 4, width of the counter value consumed and stored.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- LVLW, 3, width of the level output; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- cnt_in  input  WIDTH  current counter value from the counter register.
- capture  input  1  snapshot request; sampled on the rising edge.
- clr_ovf  input  1  clears the sticky overflow flag.
- rd_ready  input  1  consumer accepts the head entry.
- rd_valid  output  1  high when the FIFO holds at least one entry.
- rd_data  output  WIDTH+1  head entry; bit WIDTH is the wrap tag, bits WIDTH-1:0 are the count.
- level  output  LVLW  number of stored entries, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; a capture was dropped.

Behaviour:
- Reset (reset low, asynchronous):
  - Read/write pointers = 0, level = 0.
  - prev_cnt = 0, wrap_pend = 0, overflow = 0.
  - rd_valid = 0, full = 0.
  - rd_data = 0; storage contents are don't-care, but rd_data must be masked to 0 while empty.
  - Asserting reset mid-operation discards all entries.
  - The first rising edge after reset release operates normally.
- Wrap detection:
  - prev_cnt registers cnt_in every cycle.
  - wrap_now = (cnt_in < prev_cnt), an unsigned compare. For example, 15 followed by 0 is a wrap; 0 following reset is not.
  - wrap_pend is set on any cycle where wrap_now = 1 and no capture is accepted.
  - wrap_pend is cleared on an accepted capture, unless wrap_now is also 1 that cycle.
- Write:
  - A capture is accepted when capture = 1 and (!full or read_fire).
  - On acceptance, the entry {wrap_pend | wrap_now, cnt_in} is written at the write pointer, and the write pointer increments modulo DEPTH.
  - A capture with full = 1 and no read_fire is dropped; overflow is set on that edge. The FIFO is unchanged. wrap_pend keeps accumulating.
- Read:
  - read_fire = rd_valid & rd_ready.
  - rd_data is driven combinationally from the read pointer: it is valid in the same cycle rd_valid is high, with no extra latency.
  - On read_fire the read pointer increments modulo DEPTH.
  - rd_ready with rd_valid = 0 has no effect.
- Latency: an entry accepted on edge N gives rd_valid = 1 from edge N onward, i.e. it is visible in cycle N+1.
- Level:
  - +1 on an accepted write only, -1 on read_fire only, unchanged when both occur.
  - Never exceeds DEPTH and never goes below 0.
  - full and rd_valid are derived from level.
- Simultaneous write and read when full:
  - Both are performed, and level stays at DEPTH.
  - Overflow is not set.
- Simultaneous write and read when empty: the write is accepted and no read occurs, because rd_valid = 0; level becomes 1.
- Overflow:
  - Cleared by clr_ovf = 1 on an edge.
  - If a drop and clr_ovf = 1 occur on the same edge, set wins and overflow = 1.
- Ordering: strict FIFO; entries are read in capture order. Pointer wrap-around must be seamless.

Test Plan:
- Reset, then hold reset low mid-stream with 3 entries stored → rd_valid = 0, level = 0, overflow = 0, rd_data = 0 immediately, without waiting for a clock edge.
- cnt_in = 3, 4, 5 with capture on each, rd_ready = 0 → level = 3. Then rd_ready = 1 → rd_data reads 0x03, 0x04, 0x05 in order, then rd_valid = 0.
- cnt_in counts 13, 14, 15, 0, 1 with capture only at 14 and 1 → entries 0x0E (tag 0) and 0x11 (tag 1, wrap seen).
- cnt_in steps 15 → 0 with capture on the 0 cycle → entry 0x10. The next capture at 2, with no wrap in between → 0x02.
- Fill 4 entries (level = 4, full = 1), then capture of 9 with rd_ready = 0 → dropped, overflow = 1, level = 4. The same-cycle capture of 7 with rd_ready = 1 → accepted, level = 4, overflow unchanged, and the 7 is read last.
- overflow = 1, then a dropped capture and clr_ovf on the same edge → overflow = 1. Next edge: clr_ovf alone → overflow = 0.
